// File: rtl/kan_pkg.sv
// Shared types and helpers for the KAN frame sequencer.
package kan_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // Signed saturation on a 32-bit container; callers sign-extend narrower words.
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    logic signed [31:0] res;
    res = value;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/kan_sat_clamp.sv
// Combinational signed clamp of one sample word to [CLAMP_MIN, CLAMP_MAX].
module kan_sat_clamp
  import kan_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] CLAMP_MIN = 16'hC000,
  parameter logic [DATA_W-1:0] CLAMP_MAX = 16'h3FFF
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic signed [31:0] clamped;
  logic               unused_hi;

  assign clamped   = sat_clamp(32'($signed(data_i)),
                               32'($signed(CLAMP_MIN)),
                               32'($signed(CLAMP_MAX)));
  assign data_o    = clamped[DATA_W-1:0];
  // Upper bits are only sign extension once the result is inside the bounds.
  assign unused_hi = ^clamped[31:DATA_W];

endmodule

// File: rtl/kan_frame_sequencer.sv
// Packs clamped input samples into a frame for the KAN core, waits a fixed
// settle time, then captures and presents the core result on a valid/ready port.
module kan_frame_sequencer
  import kan_pkg::*;
#(
  parameter int                IN_FEATURES   = 2,
  parameter int                DATA_W        = DATA_W_DEFAULT,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [DATA_W-1:0] CLAMP_MIN     = 16'hC000,
  parameter logic [DATA_W-1:0] CLAMP_MAX     = 16'h3FFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic [IN_FEATURES*DATA_W-1:0] kan_in,
  input  logic [DATA_W-1:0]             kan_out,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int              IDX_W    = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_FEATURES - 1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [IN_FEATURES*DATA_W-1:0]   shadow_q, shadow_d;
  logic [IN_FEATURES*DATA_W-1:0]   kan_in_q, kan_in_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DATA_W-1:0]               m_data_q, m_data_d;
  logic                            m_valid_q, m_valid_d;
  logic                            frame_err_q, frame_err_d;
  logic [DATA_W-1:0]               s_clamped;
  logic                            last_slot;

  kan_sat_clamp #(
    .DATA_W   (DATA_W),
    .CLAMP_MIN(CLAMP_MIN),
    .CLAMP_MAX(CLAMP_MAX)
  ) u_clamp (
    .data_i(s_data),
    .data_o(s_clamped)
  );

  assign last_slot = (idx_q == LAST_IDX);

  // Next-state logic: frame fill/commit, settle countdown, result handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    kan_in_d    = kan_in_q;
    cnt_d       = cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          if (s_last != last_slot) begin
            // Malformed frame: drop the partial shadow and restart at slot 0.
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            for (int i = 0; i < IN_FEATURES; i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i*DATA_W +: DATA_W] = s_clamped;
            end
            if (s_last) begin
              // Commit includes the word arriving on this beat.
              kan_in_d = shadow_d;
              cnt_d    = CNT_W'(SETTLE_CYCLES);
              idx_d    = '0;
              state_d  = ST_SETTLE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          m_data_d  = kan_out;
          m_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PRESENT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow frame is only a few words, so it is reset with everything else rather than left as unreset storage.
      state_q     <= ST_FILL;
      idx_q       <= '0;
      shadow_q    <= '0;
      kan_in_q    <= '0;
      cnt_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      kan_in_q    <= kan_in_d;
      cnt_q       <= cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready   = (state_q == ST_FILL) && !reset;
  assign busy      = (state_q != ST_FILL);
  assign kan_in    = kan_in_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_kan_frame_sequencer.sv
// Randomised bench for kan_frame_sequencer against a frame-level reference model.
module tb_kan_frame_sequencer;

  localparam int NF     = 2;
  localparam int DW     = 16;
  localparam int SETTLE = 4;

  logic             clk;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             s_last;
  logic [NF*DW-1:0] kan_in;
  logic [DW-1:0]    kan_out;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic             busy;
  logic             frame_err;

  kan_frame_sequencer #(
    .IN_FEATURES  (NF),
    .DATA_W       (DW),
    .SETTLE_CYCLES(SETTLE),
    .CLAMP_MIN    (16'hC000),
    .CLAMP_MAX    (16'h3FFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .kan_in   (kan_in),
    .kan_out  (kan_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: committed vector, words gathered so far, last result.
  logic [DW-1:0] ref_kan   [NF];
  logic [DW-1:0] ref_words [NF];
  int            ref_idx;
  logic [DW-1:0] ref_mdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] clamp16(input logic [DW-1:0] w);
    int v;
    v = int'($signed(w));
    if (v < -16384) v = -16384;
    if (v > 16383) v = 16383;
    return v[DW-1:0];
  endfunction

  function automatic logic [NF*DW-1:0] exp_kan_in();
    logic [NF*DW-1:0] r;
    for (int i = 0; i < NF; i++) r[i*DW +: DW] = ref_kan[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hC000 + 16'($urandom_range(0, 2)) - 16'd1;
      3:       return 16'h3FFF + 16'($urandom_range(0, 2)) - 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at a negedge one clock after commit; result must appear exactly SETTLE clocks after commit.
  task automatic settle_present(input int hold);
    for (int k = 1; k <= SETTLE; k++) begin
      check("settle_mvalid_low", m_valid, 0);
      check("settle_busy", busy, 1);
      kan_out   = 16'($urandom);
      ref_mdata = kan_out;
      @(negedge clk);
    end
    check("present_mvalid", m_valid, 1);
    check("present_mdata", m_data, ref_mdata);
    check("present_busy", busy, 1);
    for (int h = 0; h < hold; h++) begin
      kan_out = 16'($urandom);
      @(negedge clk);
      check("hold_mvalid", m_valid, 1);
      check("hold_mdata", m_data, ref_mdata);
      check("hold_sready", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("post_hs_mvalid", m_valid, 0);
    check("post_hs_sready", s_ready, 1);
    check("post_hs_busy", busy, 0);
    check("post_hs_mdata_kept", m_data, ref_mdata);
  endtask

  // Called at a negedge one clock after commit; reset lands two settle clocks in.
  task automatic reset_in_settle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NF; i++) ref_kan[i] = '0;
    ref_idx   = 0;
    ref_mdata = '0;
    check("rst_settle_mvalid", m_valid, 0);
    check("rst_settle_sready", s_ready, 0);
    check("rst_settle_kan_in", kan_in, exp_kan_in());
    check("rst_settle_busy", busy, 0);
    check("rst_settle_mdata", m_data, ref_mdata);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_hold_mvalid", m_valid, 0);
      check("rst_hold_ferr", frame_err, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_sready", s_ready, 1);
  endtask

  // One input beat from a negedge; hold<0 means abort the settle with reset.
  task automatic do_beat(input logic [DW-1:0] d, input logic last, input int hold);
    logic is_last_slot;
    is_last_slot = (ref_idx == NF - 1);
    check("beat_sready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (last != is_last_slot) begin
      ref_idx = 0;
      check("err_pulse", frame_err, 1);
      check("err_kan_in_kept", kan_in, exp_kan_in());
      check("err_busy", busy, 0);
      @(negedge clk);
      check("err_pulse_end", frame_err, 0);
    end else begin
      ref_words[ref_idx] = clamp16(d);
      if (last) begin
        for (int i = 0; i < NF; i++) ref_kan[i] = ref_words[i];
        ref_idx = 0;
        check("commit_kan_in", kan_in, exp_kan_in());
        check("commit_busy", busy, 1);
        check("commit_sready", s_ready, 0);
        check("commit_ferr", frame_err, 0);
        if (hold < 0) reset_in_settle();
        else settle_present(hold);
      end else begin
        ref_idx++;
        check("fill_kan_in_kept", kan_in, exp_kan_in());
        check("fill_ferr", frame_err, 0);
      end
    end
  endtask

  task automatic idle_cycle();
    kan_out = 16'($urandom);
    @(negedge clk);
    check("idle_sready", s_ready, 1);
    check("idle_mvalid", m_valid, 0);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic          last;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    kan_out = '0;
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) begin
      ref_kan[i]   = '0;
      ref_words[i] = '0;
    end
    ref_idx   = 0;
    ref_mdata = '0;

    // Reset values.
    #2;
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_kan_in", kan_in, exp_kan_in());
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_mdata", m_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_sready", s_ready, 1);
    check("rel_busy", busy, 0);

    // Basic frame.
    do_beat(16'h0100, 1'b0, 0);
    do_beat(16'h0200, 1'b1, 0);
    // Saturation at both bounds.
    do_beat(16'h7000, 1'b0, 1);
    do_beat(16'h8000, 1'b1, 1);
    // Early last, then a good frame.
    do_beat(16'h0100, 1'b1, 0);
    do_beat(16'h0011, 1'b0, 0);
    do_beat(16'h0022, 1'b1, 0);
    // Missing last on the final slot.
    do_beat(16'h0555, 1'b0, 0);
    do_beat(16'h0666, 1'b0, 0);
    // Long backpressure.
    do_beat(16'h1234, 1'b0, 0);
    do_beat(16'hF000, 1'b1, 10);
    // Reset two clocks into settle, then a normal frame.
    do_beat(16'h0AAA, 1'b0, 0);
    do_beat(16'h0BBB, 1'b1, -1);
    do_beat(16'h0321, 1'b0, 0);
    do_beat(16'h0654, 1'b1, 2);

    // Random beats with gaps, random last flags and random backpressure.
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      w = rand_word();
      if (ref_idx == NF - 1) last = ($urandom_range(0, 5) != 0);
      else last = ($urandom_range(0, 5) == 0);
      do_beat(w, last, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
